// File: rtl/planta_enc_veda.sv
// Cycle-based bottle filling/sealing station plant model: sensors from actuators, bottle counter.
// Optional watchdog on the seal step is enabled with `define PLANTA_WDOG_EN.
module planta_enc_veda #(
  parameter int ENTRY_CYC = 4,
  parameter int FILL_CYC  = 8,
  parameter int CAP_CYC   = 3,
  parameter int EXIT_CYC  = 2,
  parameter int WD_CYC    = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       EV,
  input  logic       VE,
  input  logic       GC,
  output logic       PG,
  output logic       CH,
  output logic       RO,
  output logic [2:0] estado,
  output logic [7:0] contagem,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_FILL   = 3'd2,
    S_FULL   = 3'd3,
    S_CAPPED = 3'd4,
    S_EXIT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYC - 1);
  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LIM     = CNT_W'(WD_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             fault_q, fault_d;
  logic             rej_q, rej_d;
  logic             pg_q, ch_q, ro_q;
  logic             pg_d, ch_d, ro_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    count_d = count_q;
    fault_d = fault_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (cnt_q == ENTRY_LAST) state_d = S_FILL;
      end
      S_FILL: begin
        if (cnt_q == FILL_LAST) state_d = S_FULL;
      end
      S_FULL: begin
        if (!EV) cnt_d = cnt_q;
        else if (cnt_q == CAP_LAST) state_d = S_CAPPED;
      end
      S_CAPPED: begin
        // Counter measures time spent waiting for VE; it parks at the limit.
        if (cnt_q == WD_LIM) cnt_d = cnt_q;
        if (VE) begin
          state_d = S_EXIT;
        end
`ifdef PLANTA_WDOG_EN
        else if (cnt_q == WD_LIM) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          rej_d   = 1'b1;
        end
`endif
      end
      S_EXIT: begin
        if (cnt_q == EXIT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (GC && !rej_q && (count_q != 8'hFF)) count_d = count_q + 8'd1;
`ifdef PLANTA_WDOG_EN
        if (!GC) fault_d = 1'b1;
`endif
        rej_d   = 1'b0;
        state_d = run ? S_ENTRY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    pg_d = state_d inside {S_FILL, S_FULL, S_CAPPED, S_EXIT};
    ch_d = state_d inside {S_FULL, S_CAPPED, S_EXIT};
    ro_d = (state_d == S_CAPPED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
      rej_q   <= 1'b0;
      pg_q    <= 1'b0;
      ch_q    <= 1'b0;
      ro_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      fault_q <= fault_d;
      rej_q   <= rej_d;
      pg_q    <= pg_d;
      ch_q    <= ch_d;
      ro_q    <= ro_d;
    end
  end

  assign PG       = pg_q;
  assign CH       = ch_q;
  assign RO       = ro_q;
  assign estado   = state_q;
  assign contagem = count_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_planta_enc_veda.sv
// Randomized bench for planta_enc_veda against a timestamp-based bottle model.
module tb_planta_enc_veda;

  localparam int E  = 2;
  localparam int F  = 4;
  localparam int C  = 3;
  localparam int X  = 2;
  localparam int WD = 8;
`ifdef PLANTA_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, EV = 1'b0, VE = 1'b0, GC = 1'b0;
  logic       PG, CH, RO, fault;
  logic [2:0] estado;
  logic [7:0] contagem;

  planta_enc_veda #(
    .ENTRY_CYC(E), .FILL_CYC(F), .CAP_CYC(C), .EXIT_CYC(X), .WD_CYC(WD), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .EV(EV), .VE(VE), .GC(GC),
    .PG(PG), .CH(CH), .RO(RO), .estado(estado), .contagem(contagem), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: one bottle described by the edge numbers of its milestones.
  int now;
  bit busy, rej_m, fault_m;
  int start, evcnt, t_ro, t_ve, t_done, cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, now);
    end
  endtask

  function automatic int phase_of(input int c);
    if (!busy) return 0;
    if (c < start + E) return 1;
    if (c < start + E + F) return 2;
    if (t_done >= 0 && c >= t_done) return 6;
    if (t_ve >= 0) return 5;
    if (t_ro >= 0) return 4;
    return 3;
  endfunction

  task automatic new_bottle(input int at);
    busy = 1'b1; start = at; evcnt = 0;
    t_ro = -1; t_ve = -1; t_done = -1; rej_m = 1'b0;
  endtask

  task automatic model_reset();
    now = 0; busy = 1'b0; rej_m = 1'b0; fault_m = 1'b0; cnt_m = 0;
    t_ro = -1; t_ve = -1; t_done = -1;
  endtask

  task automatic model_edge();
    int p, nx;
    p  = phase_of(now);
    nx = now + 1;
    case (p)
      0: if (run) new_bottle(nx);
      3: if (EV) begin
        evcnt++;
        if (evcnt == C) t_ro = nx;
      end
      4: begin
        if (VE) begin
          t_ve = nx; t_done = nx + X;
        end else if (WDOG && (now - t_ro == WD)) begin
          t_done = nx; rej_m = 1'b1; fault_m = 1'b1;
        end
      end
      6: begin
        if (GC && !rej_m && cnt_m < 255) cnt_m++;
        if (WDOG && !GC) fault_m = 1'b1;
        if (run) new_bottle(nx);
        else busy = 1'b0;
      end
      default: ;
    endcase
    now = nx;
  endtask

  task automatic check_outputs();
    int p;
    p = phase_of(now);
    chk("estado", 32'(estado), 32'(p));
    chk("PG", 32'(PG), 32'(p >= 2 && p <= 5));
    chk("CH", 32'(CH), 32'(p >= 3 && p <= 5));
    chk("RO", 32'(RO), 32'(p == 4));
    chk("contagem", 32'(contagem), 32'(cnt_m));
    chk("fault", 32'(fault), 32'(fault_m));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic g);
    run = r; EV = e; VE = v; GC = g;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_PG", 32'(PG), 0);
    chk("rst_CH", 32'(CH), 0);
    chk("rst_RO", 32'(RO), 0);
    chk("rst_estado", 32'(estado), 0);
    chk("rst_contagem", 32'(contagem), 0);
    chk("rst_fault", 32'(fault), 0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pat[5];
    int k;
    pat = '{1, 0, 0, 1, 1};
    model_reset();
    #3;
    apply_reset();
    step();

    // Two back-to-back bottles; second one sees the EV pattern 1,0,0,1,1 in FULL.
    k = 0;
    for (int i = 0; i < 200 && cnt_m < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      if (cnt_m == 1 && phase_of(now) == 3) begin
        EV = (k < 5) ? pat[k][0] : 1'b1;
        k++;
      end
      step();
    end
    chk("two_bottles", 32'(contagem), 2);

    // Reset asserted mid-FILL.
    for (int i = 0; i < 50 && phase_of(now) != 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    step();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      step();
    end

    // run dropped in FULL: bottle still completes and is counted.
    for (int i = 0; i < 50 && phase_of(now) != 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      step();
    end
    chk("run_drop_count", 32'(contagem), 1);

    // Seal never requested for a while (watchdog window).
    for (int i = 0; i < 60 && phase_of(now) != 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      step();
    end

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) < 17));
      step();
    end

    // Saturation of the bottle counter.
    for (int i = 0; i < 6000 && cnt_m < 255; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      step();
    end
    chk("saturated", 32'(contagem), 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
